// File: rtl/sgdmac_pkg.sv
// sgdmac_pkg
// Shared definitions for the scatter-gather DMA descriptor memory slave:
// AXI response and burst-type codes, the only legal beat size, the burst
// FSM state type and a helper that classifies an AR request as unservable.
package sgdmac_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;

   localparam logic [2:0] SIZE_4B     = 3'b010;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } state_e;

   // A burst is rejected as a whole when the beat size is not one word or
   // the burst type is WRAP/reserved (both have bit 1 set).
   function automatic logic burst_bad(input logic [2:0] size,
                                      input logic [1:0] burst);
      return (size != SIZE_4B) || burst[1];
   endfunction

endpackage

// File: rtl/sgdmac_desc_ram.sv
// sgdmac_desc_ram
// Descriptor word storage: one write port, one synchronous read port.
// A read and a write of the same word on the same edge return the old word;
// the new word is visible to reads from the following edge. The array is
// never reset, so its contents survive a controller reset.
// Ports:
//   clk      - clock
//   wr_en    - write strobe
//   wr_idx   - write word index
//   wr_data  - write data
//   rd_en    - read strobe; rd_data holds its value while low
//   rd_idx   - read word index
//   rd_data  - registered read data
module sgdmac_desc_ram #(
   parameter int DEPTH = 64,
   parameter int IDX_W = 6
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [31:0]      wr_data,
   input  logic             rd_en,
   input  logic [IDX_W-1:0] rd_idx,
   output logic [31:0]      rd_data
);

   logic [31:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_idx] <= wr_data;
      if (rd_en) rd_data     <= mem[rd_idx];
   end

endmodule

// File: rtl/sgdmac_desc_mem_slave.sv
// sgdmac_desc_mem_slave
// Read-only AXI-style slave serving descriptor words from a local memory
// that the host preloads through a simple write port.
// Handshake rule: a transfer happens on a rising edge where valid and ready
// are both high; once valid is raised its payload stays constant until that
// edge, and valid never drops without a transfer (except on reset).
// One burst is served at a time: AR is accepted only in IDLE, the first R
// beat appears the cycle after acceptance and following beats stream with
// no bubble while rready_i is held high.
// Ports:
//   clk, rst_n            - clock, synchronous active-low reset
//   arid_i .. arvalid_i   - AR request; arready_o high only in IDLE
//   rid_o .. rvalid_o     - R beat outputs; rready_i accepts a beat
//   ld_en_i, ld_idx_i,
//   ld_data_i             - host preload write, usable at any time
//   state_o               - current FSM state (debug)
module sgdmac_desc_mem_slave
   import sgdmac_pkg::*;
#(
   parameter int          DEPTH_WORDS = 64,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_1000
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [3:0]                     arid_i,
   input  logic [31:0]                    araddr_i,
   input  logic [3:0]                     arlen_i,
   input  logic [2:0]                     arsize_i,
   input  logic [1:0]                     arburst_i,
   input  logic                           arvalid_i,
   output logic                           arready_o,
   output logic [3:0]                     rid_o,
   output logic [31:0]                    rdata_o,
   output logic [1:0]                     rresp_o,
   output logic                           rlast_o,
   output logic                           rvalid_o,
   input  logic                           rready_i,
   input  logic                           ld_en_i,
   input  logic [$clog2(DEPTH_WORDS)-1:0] ld_idx_i,
   input  logic [31:0]                    ld_data_i,
   output state_e                         state_o
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);

   state_e      state_q, state_d;

   logic [3:0]  id_q;
   logic [31:0] addr_q;      // byte address of the beat currently presented
   logic [3:0]  cnt_q;       // beats remaining after the presented one
   logic [1:0]  burst_q;
   logic        bad_q;       // whole burst answered with SLVERR

   logic        rvalid_q;
   logic        rlast_q;
   logic [1:0]  rresp_q;
   logic        zero_q;      // force rdata to zero for an errored beat

   logic        ar_hs;
   logic        r_hs;
   logic        fetch;       // load a new beat into the R outputs this edge
   logic        fetch_last;
   logic [31:0] fetch_addr;
   logic [29:0] fetch_word;
   logic        fetch_bad;
   logic        fetch_in_range;
   logic        fetch_err;
   logic [31:0] ram_q;
   logic        ld_ok;

   assign ar_hs = arvalid_i && (state_q == ST_IDLE);
   assign r_hs  = rvalid_q && rready_i;

   // ---------------- FSM ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      fetch      = 1'b0;
      fetch_last = 1'b0;
      fetch_addr = addr_q;
      case (state_q)
         ST_IDLE: begin
            if (ar_hs) begin
               state_d    = ST_BURST;
               fetch      = 1'b1;
               fetch_addr = araddr_i;
               fetch_last = (arlen_i == 4'd0);
            end
         end
         ST_BURST: begin
            if (r_hs) begin
               if (cnt_q == 4'd0) begin
                  state_d = ST_IDLE;
               end else begin
                  fetch      = 1'b1;
                  fetch_addr = addr_q + ((burst_q == BURST_INCR) ? 32'd4 : 32'd0);
                  fetch_last = (cnt_q == 4'd1);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // ---------------- beat address decode ----------------
   // Subtraction wraps modulo 2^32; addresses below the base are caught by
   // the explicit compare rather than by the wrapped word index.
   assign fetch_word     = 30'((fetch_addr - BASE_ADDR) >> 2);
   assign fetch_in_range = (fetch_addr >= BASE_ADDR) &&
                           ({2'b00, fetch_word} < 32'(DEPTH_WORDS));
   assign fetch_bad      = ar_hs ? burst_bad(arsize_i, arburst_i) : bad_q;
   assign fetch_err      = fetch_bad || !fetch_in_range;

   // ---------------- burst context and R registers ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         id_q     <= '0;
         addr_q   <= '0;
         cnt_q    <= '0;
         burst_q  <= BURST_FIXED;
         bad_q    <= 1'b0;
         rvalid_q <= 1'b0;
         rlast_q  <= 1'b0;
         rresp_q  <= RESP_OKAY;
         zero_q   <= 1'b1;
      end else begin
         if (ar_hs) begin
            id_q    <= arid_i;
            burst_q <= arburst_i;
            bad_q   <= burst_bad(arsize_i, arburst_i);
            cnt_q   <= arlen_i;
         end else if (fetch) begin
            cnt_q   <= cnt_q - 4'd1;
         end

         if (fetch) begin
            addr_q   <= fetch_addr;
            rvalid_q <= 1'b1;
            rlast_q  <= fetch_last;
            rresp_q  <= fetch_err ? RESP_SLVERR : RESP_OKAY;
            zero_q   <= fetch_err;
         end else if (r_hs) begin
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
         end
      end
   end

   // ---------------- storage ----------------
   assign ld_ok = ld_en_i && (32'(ld_idx_i) < 32'(DEPTH_WORDS));

   // The RAM read register only updates on a fetch, so it doubles as the
   // held rdata during R stalls.
   sgdmac_desc_ram #(
      .DEPTH (DEPTH_WORDS),
      .IDX_W (IDX_W)
   ) u_ram (
      .clk     (clk),
      .wr_en   (ld_ok),
      .wr_idx  (ld_idx_i),
      .wr_data (ld_data_i),
      .rd_en   (fetch),
      .rd_idx  (fetch_word[IDX_W-1:0]),
      .rd_data (ram_q)
   );

   assign arready_o = (state_q == ST_IDLE);
   assign rid_o     = id_q;
   assign rdata_o   = zero_q ? 32'd0 : ram_q;
   assign rresp_o   = rresp_q;
   assign rlast_o   = rlast_q;
   assign rvalid_o  = rvalid_q;
   assign state_o   = state_q;

endmodule

// File: tb/tb_sgdmac_desc_mem_slave.sv
// tb_sgdmac_desc_mem_slave
// Directed bench for the descriptor memory slave. Expected beats are pushed
// into exp_q when a burst is issued; a negedge monitor pops and compares on
// every accepted R beat and checks that stalled beats hold steady.
module tb_sgdmac_desc_mem_slave;
   import sgdmac_pkg::*;

   localparam int          DEPTH = 64;
   localparam logic [31:0] BASE  = 32'h0000_1000;

   logic        clk;
   logic        rst_n;
   logic [3:0]  arid_i;
   logic [31:0] araddr_i;
   logic [3:0]  arlen_i;
   logic [2:0]  arsize_i;
   logic [1:0]  arburst_i;
   logic        arvalid_i;
   logic        arready_o;
   logic [3:0]  rid_o;
   logic [31:0] rdata_o;
   logic [1:0]  rresp_o;
   logic        rlast_o;
   logic        rvalid_o;
   logic        rready_i;
   logic        ld_en_i;
   logic [5:0]  ld_idx_i;
   logic [31:0] ld_data_i;
   state_e      state_o;

   logic [31:0] mem_m [DEPTH];
   logic [38:0] exp_q [$];
   bit          rdy_pat [$];
   int          n_vec = 0;
   int          n_err = 0;
   logic [38:0] hold_val;
   bit          hold_v = 0;
   logic [38:0] cur_beat;
   logic [38:0] exp_beat;

   sgdmac_desc_mem_slave #(
      .DEPTH_WORDS (DEPTH),
      .BASE_ADDR   (BASE)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .arid_i    (arid_i),
      .araddr_i  (araddr_i),
      .arlen_i   (arlen_i),
      .arsize_i  (arsize_i),
      .arburst_i (arburst_i),
      .arvalid_i (arvalid_i),
      .arready_o (arready_o),
      .rid_o     (rid_o),
      .rdata_o   (rdata_o),
      .rresp_o   (rresp_o),
      .rlast_o   (rlast_o),
      .rvalid_o  (rvalid_o),
      .rready_i  (rready_i),
      .ld_en_i   (ld_en_i),
      .ld_idx_i  (ld_idx_i),
      .ld_data_i (ld_data_i),
      .state_o   (state_o)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- rready driver ----------------
   // Consumes one pattern entry per cycle in which a beat is presented.
   always begin
      @(posedge clk);
      #1;
      if (rvalid_o && rdy_pat.size() > 0) rready_i = rdy_pat.pop_front();
      else                                rready_i = 1'b1;
   end

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      cur_beat = {rid_o, rdata_o, rresp_o, rlast_o};
      if (!rst_n) begin
         hold_v = 0;
      end else begin
         if (hold_v && rvalid_o) begin
            n_vec++;
            if (cur_beat !== hold_val) begin
               n_err++;
               $display("FAIL stall_hold: got %h, required %h", cur_beat, hold_val);
            end
         end
         if (rvalid_o && !rready_i) begin
            hold_v   = 1;
            hold_val = cur_beat;
         end else begin
            hold_v = 0;
         end
         if (rvalid_o && rready_i) begin
            n_vec++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL unexpected_beat: got id=%h data=%h resp=%h last=%b, required no beat",
                        rid_o, rdata_o, rresp_o, rlast_o);
            end else begin
               exp_beat = exp_q.pop_front();
               if (cur_beat !== exp_beat) begin
                  n_err++;
                  $display("FAIL r_beat: got id=%h data=%h resp=%h last=%b, required id=%h data=%h resp=%h last=%b",
                           rid_o, rdata_o, rresp_o, rlast_o,
                           exp_beat[38:35], exp_beat[34:3], exp_beat[2:1], exp_beat[0]);
               end
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic chk(input string name, input logic [38:0] act, input logic [38:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   task automatic load(input int idx, input logic [31:0] d);
      @(posedge clk);
      #1;
      ld_en_i   = 1'b1;
      ld_idx_i  = 6'(idx);
      ld_data_i = d;
      @(posedge clk);
      #1;
      ld_en_i   = 1'b0;
      mem_m[idx] = d;
   endtask

   task automatic exp_push(input logic [3:0] id, input logic [31:0] d,
                           input logic [1:0] resp, input logic last);
      exp_q.push_back({id, d, resp, last});
   endtask

   // Issues one AR; optionally pulses a preload on the same edge as the
   // AR handshake. Checks first-beat latency.
   task automatic ar(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                     input logic [2:0] size, input logic [1:0] burst,
                     input bit ld, input int ld_idx, input logic [31:0] ld_d);
      bit ok;
      ok = 0;
      @(posedge clk);
      #1;
      arid_i    = id;
      araddr_i  = addr;
      arlen_i   = len;
      arsize_i  = size;
      arburst_i = burst;
      arvalid_i = 1'b1;
      if (ld) begin
         ld_en_i   = 1'b1;
         ld_idx_i  = 6'(ld_idx);
         ld_data_i = ld_d;
      end
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (arready_o) begin
            ok = 1;
            break;
         end
      end
      @(posedge clk);
      #1;
      arvalid_i = 1'b0;
      ld_en_i   = 1'b0;
      if (ld) mem_m[ld_idx] = ld_d;
      if (!ok) begin
         n_vec++;
         n_err++;
         $display("FAIL ar_accept: got arready=0 for 50 cycles, required 1");
      end else begin
         @(negedge clk);
         chk("first_beat_latency", 39'(rvalid_o), 39'd1);
         chk("arready_in_burst", 39'(arready_o), 39'd0);
      end
   endtask

   task automatic wait_done();
      bit ok;
      ok = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !rvalid_o) begin
            ok = 1;
            break;
         end
      end
      if (!ok) begin
         n_vec++;
         n_err++;
         $display("FAIL burst_done: got %0d beats outstanding after 200 cycles, required 0",
                  exp_q.size());
         exp_q.delete();
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst_n     = 1'b0;
      arid_i    = '0;
      araddr_i  = '0;
      arlen_i   = '0;
      arsize_i  = SIZE_4B;
      arburst_i = BURST_INCR;
      arvalid_i = 1'b0;
      rready_i  = 1'b1;
      ld_en_i   = 1'b0;
      ld_idx_i  = '0;
      ld_data_i = '0;
      for (int i = 0; i < DEPTH; i++) mem_m[i] = 32'hx;

      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_arready", 39'(arready_o), 39'd1);
      chk("rst_rvalid",  39'(rvalid_o),  39'd0);
      chk("rst_rlast",   39'(rlast_o),   39'd0);
      chk("rst_rid",     39'(rid_o),     39'd0);
      chk("rst_rdata",   39'(rdata_o),   39'd0);
      chk("rst_rresp",   39'(rresp_o),   39'd0);
      chk("rst_state",   39'(state_o),   39'(ST_IDLE));

      for (int i = 0; i < 4; i++) load(i, 32'h0000_00A0 + 32'(i));
      load(62, 32'hDEAD_0062);
      load(63, 32'hDEAD_0063);

      // Four-beat INCR burst, rready always high.
      for (int i = 0; i < 4; i++) exp_push(4'd5, mem_m[i], RESP_OKAY, i == 3);
      ar(4'd5, 32'h0000_1000, 4'd3, SIZE_4B, BURST_INCR, 0, 0, 0);
      wait_done();

      // Same burst with back-pressure 1-0-0-1-0-1-1.
      rdy_pat = '{1, 0, 0, 1, 0, 1, 1};
      for (int i = 0; i < 4; i++) exp_push(4'd6, mem_m[i], RESP_OKAY, i == 3);
      ar(4'd6, 32'h0000_1000, 4'd3, SIZE_4B, BURST_INCR, 0, 0, 0);
      wait_done();

      // Burst running off the end of the memory.
      exp_push(4'd2, mem_m[62], RESP_OKAY,   1'b0);
      exp_push(4'd2, mem_m[63], RESP_OKAY,   1'b0);
      exp_push(4'd2, 32'd0,     RESP_SLVERR, 1'b0);
      exp_push(4'd2, 32'd0,     RESP_SLVERR, 1'b1);
      ar(4'd2, BASE + 32'd248, 4'd3, SIZE_4B, BURST_INCR, 0, 0, 0);
      wait_done();

      // WRAP burst rejected, then a single FIXED beat.
      exp_push(4'd3, 32'd0, RESP_SLVERR, 1'b0);
      exp_push(4'd3, 32'd0, RESP_SLVERR, 1'b1);
      ar(4'd3, 32'h0000_1000, 4'd1, SIZE_4B, 2'b10, 0, 0, 0);
      wait_done();
      exp_push(4'd4, mem_m[1], RESP_OKAY, 1'b1);
      ar(4'd4, 32'h0000_1004, 4'd0, SIZE_4B, BURST_FIXED, 0, 0, 0);
      wait_done();

      // Wrong beat size rejected.
      exp_push(4'd7, 32'd0, RESP_SLVERR, 1'b1);
      ar(4'd7, 32'h0000_1000, 4'd0, 3'b001, BURST_INCR, 0, 0, 0);
      wait_done();

      // FIXED burst repeats one word, with stalls.
      rdy_pat = '{0, 1, 0, 1, 1};
      for (int i = 0; i < 3; i++) exp_push(4'd8, mem_m[2], RESP_OKAY, i == 2);
      ar(4'd8, 32'h0000_1008, 4'd2, SIZE_4B, BURST_FIXED, 0, 0, 0);
      wait_done();

      // Start below the base: first beat errors, second beat is word 0.
      exp_push(4'd9, 32'd0,    RESP_SLVERR, 1'b0);
      exp_push(4'd9, mem_m[0], RESP_OKAY,   1'b1);
      ar(4'd9, 32'h0000_0FFC, 4'd1, SIZE_4B, BURST_INCR, 0, 0, 0);
      wait_done();

      // Low address bits ignored.
      exp_push(4'd10, mem_m[1], RESP_OKAY, 1'b1);
      ar(4'd10, 32'h0000_1006, 4'd0, SIZE_4B, BURST_FIXED, 0, 0, 0);
      wait_done();

      // Preload of word 3 on the same edge as its fetch: old then new.
      exp_push(4'd11, mem_m[3],     RESP_OKAY, 1'b0);
      exp_push(4'd11, 32'h5555_AAAA, RESP_OKAY, 1'b1);
      ar(4'd11, 32'h0000_100C, 4'd1, SIZE_4B, BURST_FIXED, 1, 3, 32'h5555_AAAA);
      wait_done();

      // Reset while beat 2 of a four-beat burst is stalled.
      rdy_pat = '{1, 1, 0};
      exp_push(4'd12, mem_m[0], RESP_OKAY, 1'b0);
      exp_push(4'd12, mem_m[1], RESP_OKAY, 1'b0);
      ar(4'd12, 32'h0000_1000, 4'd3, SIZE_4B, BURST_INCR, 0, 0, 0);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      rdy_pat.delete();
      @(negedge clk);
      chk("abort_rvalid",  39'(rvalid_o),  39'd0);
      chk("abort_arready", 39'(arready_o), 39'd1);
      chk("abort_rlast",   39'(rlast_o),   39'd0);
      chk("abort_beats_left", 39'(exp_q.size()), 39'd0);
      exp_q.delete();
      repeat (4) @(negedge clk);

      // Memory survives reset.
      for (int i = 0; i < 4; i++) exp_push(4'd13, mem_m[i], RESP_OKAY, i == 3);
      ar(4'd13, 32'h0000_1000, 4'd3, SIZE_4B, BURST_INCR, 0, 0, 0);
      wait_done();

      chk("scoreboard_empty", 39'(exp_q.size()), 39'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/sgdmac_desc_mem_slave.md
SGDMAC_DESC_MEM_SLAVE -- requirements
Module: sgdmac_desc_mem_slave

Interface
REQ-001 Parameter DEPTH_WORDS, default 64, number of 32-bit descriptor words stored.
REQ-002 Parameter BASE_ADDR, default 32'h0000_1000, byte address of word 0.
REQ-003 Port clk, input, 1, clock; all logic on rising edge.
REQ-004 Port rst_n, input, 1, reset, synchronous, active-low.
REQ-005 Port arid_i, input, 4, read ID.
REQ-006 Port araddr_i, input, 32, burst start byte address.
REQ-007 Port arlen_i, input, 4, beats minus one.
REQ-008 Port arsize_i, input, 3, beat size code.
REQ-009 Port arburst_i, input, 2, burst type.
REQ-010 Port arvalid_i, input, 1; arready_o, output, 1; AR handshake.
REQ-011 Port rid_o, output, 4, echo of accepted arid_i.
REQ-012 Port rdata_o, output, 32, beat data.
REQ-013 Port rresp_o, output, 2, beat response (OKAY 2'b00, SLVERR 2'b10).
REQ-014 Port rlast_o, output, 1, final beat marker.
REQ-015 Port rvalid_o, output, 1; rready_i, input, 1; R handshake.
REQ-016 Port ld_en_i, input, 1; ld_idx_i, input, clog2(DEPTH_WORDS); ld_data_i, input, 32; host preload write port.

Function
REQ-017 States IDLE and BURST only; one outstanding burst, no AR queueing.
REQ-018 arready_o SHALL be 1 exactly when state is IDLE.
REQ-019 On arvalid_i&arready_o: latch id, addr, len, burst; beat counter = arlen_i; go to BURST.
REQ-020 First rvalid_o SHALL assert the cycle after AR handshake (latency 1); beat 0 data from araddr_i.
REQ-021 R outputs are registered; rid/rdata/rresp/rlast SHALL stay stable while rvalid_o&!rready_i.
REQ-022 On rvalid_o&rready_i with counter>0: load next beat next cycle, rvalid_o stays 1, no bubble.
REQ-023 rlast_o SHALL be 1 only on the beat where counter==0.
REQ-024 On last-beat handshake: rvalid_o=0 next cycle, state IDLE; next AR accepted earliest that cycle.
REQ-025 Address step: INCR (2'b01) +4 per beat; FIXED (2'b00) no increment; 32-bit wrap-around ignored (modulo 2^32).
REQ-026 Word index = (addr - BASE_ADDR) >> 2; addr[1:0] ignored.
REQ-027 Beat out of range (addr < BASE_ADDR or index >= DEPTH_WORDS): rresp SLVERR, rdata 0; other beats of burst unaffected.
REQ-028 arsize_i != 3'b010 or arburst_i in {2'b10, 2'b11}: all arlen_i+1 beats SLVERR, rdata 0, full beat count still returned.
REQ-029 ld_en_i writes ld_data_i to word ld_idx_i at clock edge; ld_idx_i >= DEPTH_WORDS ignored.
REQ-030 Load and beat fetch of same word in same cycle: beat returns old data; load visible from next cycle.
REQ-031 Load port usable in any state; does not stall R channel.

Reset
REQ-032 rst_n low: state IDLE, arready_o 1 after reset release, rvalid_o 0, rlast_o 0, rid_o 0, rdata_o 0, rresp_o 0, counter 0.
REQ-033 Reset mid-burst SHALL abort burst, no further beats; memory contents SHALL NOT be cleared.

Structure
REQ-034 Package sgdmac_pkg holds RESP_OKAY/RESP_SLVERR, BURST_FIXED/INCR, SIZE_4B, state enum.
REQ-035 Storage in one sub-module sgdmac_desc_ram (1 write port, 1 sync read port, no reset on array).

Verification
REQ-036 Load 0x1000..0x100C with A0,A1,A2,A3; AR id=5 addr=0x1000 len=3 INCR -> 4 beats A0..A3, rid 5, OKAY, rlast only beat 4, rvalid 1 cycle after AR.
REQ-037 Same burst, rready 1-0-0-1-0-1-1 -> data/rlast held stable during stalls, order A0..A3, no drop/dup.
REQ-038 AR addr=BASE+4*62 len=3 (DEPTH 64) -> beats 0,1 OKAY with words 62,63; beats 2,3 SLVERR data 0.
REQ-039 AR arburst=2'b10 len=1 -> 2 SLVERR beats data 0; then AR len=0 FIXED addr 0x1004 -> 1 OKAY beat word 1.
REQ-040 rst_n low during beat 2 of len=3 burst -> rvalid 0, arready 1 after release, new burst returns preloaded data unchanged.
